mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
  localparam int unsigned DW = 32;

  logic          I_req;
  logic [DW-1:0] I_addr;
  logic          I_ack;
  logic [DW-1:0] I_rdata;
  logic          D_req;
  logic          D_we;
  logic [DW-1:0] D_addr;
  logic [DW-1:0] D_wdata;
  logic          D_ack;
  logic [DW-1:0] D_rdata;
  logic          Err;
  logic [DW-1:0] Address;
  logic [DW-1:0] writeData;
  logic          writeEnable;
  logic [DW-1:0] MemData;

  modport slave (
    input  I_req, I_addr, D_req, D_we, D_addr, D_wdata, MemData,
    output I_ack, I_rdata, D_ack, D_rdata, Err, Address, writeData, writeEnable
  );

  modport master (
    output I_req, I_addr, D_req, D_we, D_addr, D_wdata, MemData,
    input  I_ack, I_rdata, D_ack, D_rdata, Err, Address, writeData, writeEnable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between an instruction
// fetch port and a data port; one transaction in flight, IDLE -> ACCESS -> RESP.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input logic          Clk,
  input logic          Reset_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state, next_state;
  logic           last_grant;   // 1 = data port won the previous grant
  logic           lat_d;
  logic           lat_oob;
  logic           grant;
  logic           grant_d;
  logic           capture;
  logic [AW-1:0]  sel_addr;
  logic           sel_oob;
  logic [AW-1:0]  cap_data;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and grant decision; data port wins a tie unless it won last time
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (bus.I_req || bus.D_req) begin
          grant      = 1'b1;
          grant_d    = bus.D_req && (!bus.I_req || !last_grant);
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        capture    = 1'b1;
        next_state = RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  assign sel_addr = grant_d ? bus.D_addr : bus.I_addr;
  assign sel_oob  = (sel_addr >= AW'(MEM_WORDS));
  assign cap_data = lat_oob ? '0 : bus.MemData;

  // Grant latching, memory strobe, read capture and response pulses
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant      <= 1'b0;
      lat_d           <= 1'b0;
      lat_oob         <= 1'b0;
      bus.Address     <= '0;
      bus.writeData   <= '0;
      bus.writeEnable <= 1'b0;
      bus.I_ack       <= 1'b0;
      bus.D_ack       <= 1'b0;
      bus.Err         <= 1'b0;
      bus.I_rdata     <= '0;
      bus.D_rdata     <= '0;
    end else begin
      bus.writeEnable <= 1'b0;
      bus.I_ack       <= 1'b0;
      bus.D_ack       <= 1'b0;
      bus.Err         <= 1'b0;
      if (grant) begin
        last_grant      <= grant_d;
        lat_d           <= grant_d;
        lat_oob         <= sel_oob;
        bus.Address     <= sel_addr;
        if (grant_d) bus.writeData <= bus.D_wdata;
        bus.writeEnable <= grant_d && bus.D_we && !sel_oob;
      end
      if (capture) begin
        if (lat_d) begin
          bus.D_rdata <= cap_data;
          bus.D_ack   <= 1'b1;
        end else begin
          bus.I_rdata <= cap_data;
          bus.I_ack   <= 1'b1;
        end
        bus.Err <= lat_oob;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// reference model with its own copy of memory.
module tb_mem_arbiter;
  localparam int unsigned MEM_WORDS = 1024;

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) u_dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Memory behind the arbiter: combinational read, write on clock edge
  logic [31:0] mem [MEM_WORDS];
  assign bus.MemData = (bus.Address < MEM_WORDS) ? mem[bus.Address[9:0]] : 32'hdeadbeef;
  always @(posedge Clk) if (bus.writeEnable && bus.Address < MEM_WORDS) mem[bus.Address[9:0]] <= bus.writeData;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  logic [31:0] refm [MEM_WORDS];
  bit          pend_v, pend_d, pend_we, pend_oob, last_port;
  logic [31:0] pend_addr, pend_wdata;
  bit          exp_iack, exp_dack, exp_err, exp_we;
  logic [31:0] exp_wdata, mdl_addr, mdl_irdata, mdl_drdata;
  int          ack_cnt;
  logic [7:0]  ack_order;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_v = 0; last_port = 0;
    exp_iack = 0; exp_dack = 0; exp_err = 0; exp_we = 0;
    mdl_addr = '0; mdl_irdata = '0; mdl_drdata = '0;
  endtask

  // One clock edge of the transaction model: finish the access in flight,
  // otherwise start a new one chosen round-robin from the sampled requests.
  task automatic model_step();
    bit          can_grant, pick_d;
    logic [31:0] val;
    can_grant = !pend_v;
    exp_iack = 0; exp_dack = 0; exp_err = 0; exp_we = 0;
    if (pend_v) begin
      val = pend_oob ? 32'h0 : refm[pend_addr[9:0]];
      if (pend_d) begin exp_dack = 1; mdl_drdata = val; end
      else        begin exp_iack = 1; mdl_irdata = val; end
      exp_err = pend_oob;
      if (pend_d && pend_we && !pend_oob) refm[pend_addr[9:0]] = pend_wdata;
      pend_v = 0;
    end
    if (can_grant && (bus.I_req || bus.D_req)) begin
      pick_d     = bus.D_req && (!bus.I_req || !last_port);
      last_port  = pick_d;
      pend_v     = 1;
      pend_d     = pick_d;
      pend_addr  = pick_d ? bus.D_addr : bus.I_addr;
      pend_we    = pick_d && bus.D_we;
      pend_wdata = bus.D_wdata;
      pend_oob   = pend_addr >= MEM_WORDS;
      mdl_addr   = pend_addr;
      exp_we     = pend_we && !pend_oob;
      exp_wdata  = bus.D_wdata;
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("i_ack", 32'(bus.I_ack), 32'(exp_iack));
    check("d_ack", 32'(bus.D_ack), 32'(exp_dack));
    check("err", 32'(bus.Err), 32'(exp_err));
    check("we", 32'(bus.writeEnable), 32'(exp_we));
    check("address", bus.Address, mdl_addr);
    check("i_rdata", bus.I_rdata, mdl_irdata);
    check("d_rdata", bus.D_rdata, mdl_drdata);
    if (exp_we) check("wdata", bus.writeData, exp_wdata);
    if (bus.I_ack || bus.D_ack) begin
      ack_cnt++;
      ack_order = {ack_order[6:0], bus.D_ack};
    end
  endtask

  task automatic idle_inputs();
    bus.I_req = 0; bus.I_addr = '0;
    bus.D_req = 0; bus.D_we = 0; bus.D_addr = '0; bus.D_wdata = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 32'(1024 + $urandom_range(0, 50)) : 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] v;
    n_checks = 0; n_errors = 0; ack_cnt = 0; ack_order = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      v = $urandom; mem[i] = v; refm[i] = v;
    end
    mem[128] = 32'h8c030000; refm[128] = 32'h8c030000;
    idle_inputs();
    model_reset();
    Reset_n = 1;
    #1 Reset_n = 0;
    #1;
    check("rst_we", 32'(bus.writeEnable), 0);
    check("rst_acks", {29'd0, bus.I_ack, bus.D_ack, bus.Err}, 0);
    check("rst_rdata", bus.I_rdata | bus.D_rdata, 0);
    check("rst_addr", bus.Address | bus.writeData, 0);
    @(posedge Clk); @(negedge Clk);
    Reset_n = 1;

    // Contention straight after reset: D,I,D,I with acks every other cycle
    bus.I_req = 1; bus.I_addr = 32'd3;
    bus.D_req = 1; bus.D_addr = 32'd4;
    ack_cnt = 0; ack_order = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 1 || k == 3 || k == 5 || k == 7) check("cont_ack_slot", 32'(bus.I_ack | bus.D_ack), 1);
    end
    idle_inputs();
    check("cont_count", 32'(ack_cnt), 4);
    check("cont_order", 32'(ack_order[3:0]), 32'b1010);
    cycle();

    // Single fetch from word 128
    bus.I_req = 1; bus.I_addr = 32'd128;
    cycle(); cycle();
    check("fetch_ack", {30'd0, bus.I_ack, bus.D_ack}, 32'b10);
    check("fetch_data", bus.I_rdata, 32'h8c030000);
    check("fetch_err", 32'(bus.Err), 0);
    idle_inputs();
    cycle();

    // Data write to 6 then read back
    bus.D_req = 1; bus.D_we = 1; bus.D_addr = 32'd6; bus.D_wdata = 32'd13;
    cycle();
    check("wr_strobe", {31'd0, bus.writeEnable}, 1);
    check("wr_address", bus.Address, 32'd6);
    cycle();
    check("wr_ack", {31'd0, bus.D_ack}, 1);
    check("wr_strobe_once", {31'd0, bus.writeEnable}, 0);
    bus.D_we = 0; bus.D_wdata = '0;
    cycle(); cycle();
    check("rd_ack", {31'd0, bus.D_ack}, 1);
    check("rd_data", bus.D_rdata, 32'd13);
    idle_inputs();
    cycle();

    // Out-of-range write
    bus.D_req = 1; bus.D_we = 1; bus.D_addr = 32'd1024; bus.D_wdata = 32'h55;
    cycle();
    check("oob_no_strobe", {31'd0, bus.writeEnable}, 0);
    cycle();
    check("oob_ack_err", {30'd0, bus.D_ack, bus.Err}, 32'b11);
    check("oob_rdata", bus.D_rdata, 0);
    idle_inputs();
    cycle();

    // Isolated single-cycle fetch pulses every 5 cycles
    ack_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      bus.I_req = 1; bus.I_addr = 32'($urandom_range(0, 15));
      cycle();
      bus.I_req = 0;
      cycle();
      check("gap_ack", {31'd0, bus.I_ack}, 1);
      for (int k = 0; k < 3; k++) cycle();
    end
    check("gap_count", 32'(ack_cnt), 4);

    // Reset while a write is in its access cycle
    bus.D_req = 1; bus.D_we = 1; bus.D_addr = 32'd7; bus.D_wdata = ~refm[7];
    cycle();
    check("abort_strobe_pre", {31'd0, bus.writeEnable}, 1);
    Reset_n = 0;
    #1;
    check("abort_strobe", {31'd0, bus.writeEnable}, 0);
    check("abort_addr", bus.Address, 0);
    model_reset();
    idle_inputs();
    @(posedge Clk); @(negedge Clk);
    Reset_n = 1;
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) cycle();
    check("abort_no_ack", 32'(ack_cnt), 0);
    check("abort_mem", mem[7], refm[7]);

    // Randomized traffic; requesters hold their request until acknowledged
    for (int k = 0; k < 400; k++) begin
      if (bus.I_ack || (!bus.I_req && $urandom_range(0, 2) == 0)) begin
        bus.I_req = bus.I_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.I_addr = rand_addr();
      end
      if (bus.D_ack || (!bus.D_req && $urandom_range(0, 2) == 0)) begin
        bus.D_req = bus.D_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.D_we = 1'($urandom_range(0, 1));
        bus.D_addr = rand_addr();
        bus.D_wdata = $urandom;
      end
      cycle();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle();
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], refm[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
